// File: rtl/mem_access_pkg.sv
// ============================================================================
//  Module      : mem_access_pkg
//  Description : Shared size encodings, FSM state type and width defaults
//                for the data-memory access unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_IDX_W  = 12;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/mau_lane_merge.sv
// ============================================================================
//  Module      : mau_lane_merge
//  Description : Combinational store-lane merge and load extract/extend for
//                little-endian byte/half/word accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mau_lane_merge
    import mem_access_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [1:0]        size_i,
    input  logic              signed_i,
    input  logic [1:0]        lane_i,
    input  logic [DATA_W-1:0] word_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] merged_o,
    output logic [DATA_W-1:0] load_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte   = word_i[{lane_i, 3'b000} +: 8];
        w_half   = lane_i[1] ? word_i[31:16] : word_i[15:0];
        merged_o = word_i;
        load_o   = word_i;
        case (size_i)
            SZ_BYTE: begin
                merged_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
                load_o = {{(DATA_W-8){signed_i & w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                // Half lane is chosen by addr[1] alone; addr[0] never splits a half.
                if (lane_i[1]) begin
                    merged_o[31:16] = wdata_i[15:0];
                end else begin
                    merged_o[15:0]  = wdata_i[15:0];
                end
                load_o = {{(DATA_W-16){signed_i & w_half[15]}}, w_half};
            end
            default: begin
                merged_o = wdata_i;
                load_o   = word_i;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
//  Module      : mem_access_unit
//  Description : Load/store sequencer on a word-addressed memory bus; sub-word
//                stores use read-modify-write. Optional misaligned-access trap
//                enabled by defining MISALIGN_TRAP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int IDX_W  = DEF_IDX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e              state_q, state_d;
    logic                write_q, write_d;
    logic [1:0]          size_q, size_d;
    logic                signed_q, signed_d;
    logic [IDX_W+1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                err_q, err_d;

    logic [1:0]          w_req_size;
    logic                w_misalign;
    logic [DATA_W-1:0]   w_merged;
    logic [DATA_W-1:0]   w_load;
    logic                w_unused_addr_hi;

    // Reserved size 2'b11 is folded into word at the request boundary.
    assign w_req_size = req_size[1] ? SZ_WORD : req_size;

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = ((w_req_size == SZ_HALF) && req_addr[0]) ||
                        ((w_req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    // Byte addresses above the memory window alias by truncation.
    assign w_unused_addr_hi = ^req_addr[ADDR_W-1:IDX_W+2];

    mau_lane_merge #(
        .DATA_W (DATA_W)
    ) u_lane_merge (
        .size_i   (size_q),
        .signed_i (signed_q),
        .lane_i   (addr_q[1:0]),
        .word_i   (mem_rdata),
        .wdata_i  (wdata_q),
        .merged_o (w_merged),
        .load_o   (w_load)
    );

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        size_d      = size_q;
        signed_d    = signed_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mem_wdata_d = mem_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d     = req_write;
                    size_d      = w_req_size;
                    signed_d    = req_signed;
                    addr_d      = req_addr[IDX_W+1:0];
                    wdata_d     = req_wdata;
                    rsp_rdata_d = '0;
                    if (w_misalign) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (req_write && (w_req_size == SZ_WORD)) begin
                        mem_wdata_d = req_wdata;
                        state_d     = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                // mem_rdata is only valid here; it is consumed at the closing edge.
                if (write_q) begin
                    mem_wdata_d = w_merged;
                    state_d     = ST_WR;
                end else begin
                    rsp_rdata_d = w_load;
                    state_d     = ST_RESP;
                end
            end
            ST_WR: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_rdata_d = '0;
                err_d       = 1'b0;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            size_q      <= SZ_BYTE;
            signed_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_wdata_q <= '0;
            rsp_rdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            err_q       <= err_d;
        end
    end

    // Bus strobes decode straight from state so an async reset kills them at once.
    assign req_ready = (state_q == ST_IDLE);
    assign mem_read  = (state_q == ST_RD);
    assign mem_write = (state_q == ST_WR);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = err_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_addr  = {{(32-IDX_W){1'b0}}, addr_q[IDX_W+1:2]};

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Self-checking bench for mem_access_unit (vector table,
//                corner sequences, random traffic against a reference model).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    wire  [31:0] mem_rdata;

    logic [31:0] bus_mem [4096];
    logic [31:0] ref_mem [4096];

    int total = 0;
    int bad   = 0;

    mem_access_unit u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-wide memory: combinational read, write on the rising edge.
    assign mem_rdata = mem_read ? bus_mem[mem_addr[11:0]] : 32'hzzzz_zzzz;
    always @(posedge clk) begin
        if (mem_write) bus_mem[mem_addr[11:0]] <= mem_wdata;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%08h required=%08h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model_load(logic [31:0] word, int nb, int off, bit sg);
        longint v;
        v = longint'((64'(word) >> (8 * off)) & ((64'd1 << (8 * nb)) - 64'd1));
        if (sg && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
            v = v - (longint'(1) << (8 * nb));
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_store(logic [31:0] word, logic [31:0] wd, int nb, int off);
        logic [63:0] m;
        logic [63:0] d;
        m = ((64'd1 << (8 * nb)) - 64'd1) << (8 * off);
        d = 64'(wd) << (8 * off);
        return (word & ~m[31:0]) | (d[31:0] & m[31:0]);
    endfunction

    // Reference: what the request should return and do to memory.
    task automatic model_req(input logic w, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input logic [31:0] wd,
                             output logic [31:0] e_rdata, output logic e_err,
                             output int e_lat, output int e_rd, output int e_wr);
        int nb, off, idx;
        bit mis;
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = (nb == 1) ? int'(a[1:0]) : (nb == 2) ? 2 * int'(a[1]) : 0;
        idx = int'(a[13:2]);
        mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
        mis = (nb == 2 && a[0]) || (nb == 4 && a[1:0] != 2'b00);
`endif
        if (mis) begin
            e_rdata = 32'h0; e_err = 1'b1; e_lat = 1; e_rd = 0; e_wr = 0;
        end else if (!w) begin
            e_rdata = model_load(ref_mem[idx], nb, off, sg);
            e_err = 1'b0; e_lat = 2; e_rd = 1; e_wr = 0;
        end else begin
            ref_mem[idx] = model_store(ref_mem[idx], wd, nb, off);
            e_rdata = 32'h0; e_err = 1'b0;
            e_lat = (nb == 4) ? 2 : 3; e_rd = (nb == 4) ? 0 : 1; e_wr = 1;
        end
    endtask

    task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] g_rdata, output logic g_err,
                           output int lat, output int nrd, output int nwr,
                           output logic [31:0] obs_addr, output logic seen);
        req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1; nrd = 0; nwr = 0; obs_addr = 32'h0; g_rdata = 32'h0; g_err = 1'b0;
        while (!rsp_valid && lat < 8) begin
            if (mem_read)  nrd++;
            if (mem_write) nwr++;
            if (mem_read || mem_write) obs_addr = mem_addr;
            @(posedge clk); #1;
            lat++;
        end
        seen = rsp_valid;
        if (seen) begin
            g_rdata = rsp_rdata;
            g_err   = rsp_err;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_full(input string nm, input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] got, output int got_lat);
        logic [31:0] e_rdata, g_rdata, obs;
        logic        e_err, g_err, seen;
        int          e_lat, e_rd, e_wr, lat, nrd, nwr, idx;
        idx = int'(a[13:2]);
        check({nm, " ready"}, {31'b0, req_ready}, 32'd1);
        model_req(w, sz, sg, a, wd, e_rdata, e_err, e_lat, e_rd, e_wr);
        run_req(w, sz, sg, a, wd, g_rdata, g_err, lat, nrd, nwr, obs, seen);
        check({nm, " rsp_seen"}, {31'b0, seen}, 32'd1);
        check({nm, " rdata"}, g_rdata, e_rdata);
        check({nm, " err"}, {31'b0, g_err}, {31'b0, e_err});
        check({nm, " latency"}, 32'(lat), 32'(e_lat));
        check({nm, " rd_cycles"}, 32'(nrd), 32'(e_rd));
        check({nm, " wr_cycles"}, 32'(nwr), 32'(e_wr));
        if (e_rd + e_wr > 0) check({nm, " mem_addr"}, obs, {20'h0, a[13:2]});
        check({nm, " mem_word"}, bus_mem[idx], ref_mem[idx]);
        check({nm, " pulse_end"}, {31'b0, rsp_valid}, 32'd0);
        got = g_rdata;
        got_lat = lat;
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t tab [15];

    task automatic check_reset_outputs(input string nm);
        check({nm, " req_ready"}, {31'b0, req_ready}, 32'd1);
        check({nm, " rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
        check({nm, " rsp_err"},   {31'b0, rsp_err},   32'd0);
        check({nm, " mem_read"},  {31'b0, mem_read},  32'd0);
        check({nm, " mem_write"}, {31'b0, mem_write}, 32'd0);
        check({nm, " rsp_rdata"}, rsp_rdata, 32'd0);
        check({nm, " mem_addr"},  mem_addr,  32'd0);
        check({nm, " mem_wdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        logic [31:0] got, a, wd;
        int          got_lat;
        logic        w, sg;
        logic [1:0]  sz;

        tab[0]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 2};
        tab[1]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 2};
        tab[2]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0020, 32'h1122_3344, 32'h0000_0000, 2};
        tab[3]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0023, 32'h0000_00AA, 32'h0000_0000, 3};
        tab[4]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0,         32'hAA22_3344, 2};
        tab[5]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0030, 32'h8000_0000, 32'h0000_0000, 2};
        tab[6]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0033, 32'h0,         32'hFFFF_FF80, 2};
        tab[7]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0033, 32'h0,         32'h0000_0080, 2};
        tab[8]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0040, 32'h8001_FFFF, 32'h0000_0000, 2};
        tab[9]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0042, 32'h0,         32'hFFFF_8001, 2};
        tab[10] = '{1'b0, 2'd1, 1'b0, 32'h0000_0040, 32'h0,         32'h0000_FFFF, 2};
        tab[11] = '{1'b1, 2'd1, 1'b0, 32'h0000_0042, 32'h0000_1234, 32'h0000_0000, 3};
        tab[12] = '{1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0,         32'h1234_FFFF, 2};
        tab[13] = '{1'b0, 2'd3, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 2};
        tab[14] = '{1'b0, 2'd2, 1'b0, 32'h0000_4010, 32'h0,         32'hDEAD_BEEF, 2};

        for (int i = 0; i < 4096; i++) begin
            bus_mem[i] = $urandom;
            ref_mem[i] = bus_mem[i];
        end

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        #3;
        check_reset_outputs("reset_async");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_reset_outputs("reset_release");

        for (int i = 0; i < 15; i++) begin
            do_full($sformatf("vec%0d", i), tab[i].w, tab[i].sz, tab[i].sg,
                    tab[i].addr, tab[i].wdata, got, got_lat);
            check($sformatf("vec%0d table_rdata", i), got, tab[i].exp_rdata);
            check($sformatf("vec%0d table_lat", i), 32'(got_lat), 32'(tab[i].exp_lat));
        end

        // Misaligned word load: trapped with the macro, word index 1 without it.
        do_full("misalign", 1'b0, 2'd2, 1'b0, 32'h0000_0005, 32'h0, got, got_lat);

        // Requests presented while busy must be ignored.
        req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
        @(posedge clk); #1;
        req_write = 1'b1; req_wdata = 32'h0BAD_0BAD;
        @(posedge clk); #1;
        check("busy rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check("busy rsp_rdata", rsp_rdata, ref_mem[4]);
        check("busy req_ready", {31'b0, req_ready}, 32'd0);
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("busy no_write", {31'b0, mem_write}, 32'd0);
        check("busy mem_word", bus_mem[4], ref_mem[4]);

        // Reset asserted in the middle of a word-store WR cycle.
        do_full("pre_abort", 1'b1, 2'd2, 1'b0, 32'h50, 32'h0102_0304, got, got_lat);
        req_write = 1'b1; req_size = 2'd2; req_addr = 32'h50; req_wdata = 32'h5555_5555;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("abort wr_active", {31'b0, mem_write}, 32'd1);
        check("abort wr_addr", mem_addr, 32'h14);
        check("abort wr_data", mem_wdata, 32'h5555_5555);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("abort_reset");
        @(posedge clk); #1;
        check("abort mem_word", bus_mem[20], 32'h0102_0304);
        rst_n = 1'b1;
        do_full("post_abort", 1'b0, 2'd2, 1'b0, 32'h50, 32'h0, got, got_lat);
        check("post_abort value", got, 32'h0102_0304);

        for (int i = 0; i < 150; i++) begin
            w  = 1'($urandom % 2);
            sz = 2'($urandom % 4);
            sg = 1'($urandom % 2);
            a  = ($urandom & 32'hFFFF_C000) | ($urandom & 32'h0000_003F);
            wd = $urandom;
            do_full($sformatf("rnd%0d", i), w, sz, sg, a, wd, got, got_lat);
        end

        for (int i = 0; i < 16; i++)
            check($sformatf("final_mem%0d", i), bus_mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
